// File: rtl/ale_pkg.sv
// Shared definitions for the chunk loader and the miner top: size defaults, loader states, word-count helper.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
// Contents: DEF_NONCE_BYTE_LEN, DEF_MAX_WORDS, ld_state_e, words_from_len().
package ale_pkg;

  // Nonce bytes counted in ChunkLength but generated by the miner, not streamed.
  localparam int DEF_NONCE_BYTE_LEN = 24;
  // Miner chunk memory is 6x16 words, minus the 6 words the nonce occupies.
  localparam int DEF_MAX_WORDS      = 90;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } ld_state_e;

  // Words written for a chunk: ceil((chunk_len - nonce_len) / 4) in 32-bit
  // unsigned arithmetic. The miner uses the same helper so both agree on W.
  function automatic logic [31:0] words_from_len(input logic [31:0] chunk_len,
                                                 input logic [31:0] nonce_len);
    logic [31:0] payload;
    payload = chunk_len - nonce_len;
    return (payload + 32'd3) >> 2;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; zero-fills a short final word.
// Latency: word appears one cycle after the byte that completes it (lane 3 or last byte).
// Backpressure: none; caller only pushes when it can accept, clear drops a partial word.
// Ports: clk/rst_n; clear (drop partial), push/last/lane/din (byte in); word_vld/word_dat (registered word out).
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic        last,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [31:0] acc_q;
  logic [31:0] merged;
  logic        vld_q;
  logic [31:0] dat_q;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    merged = acc_q;
    merged[{lane, 3'b000} +: 8] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
      vld_q <= 1'b0;
    end else if (push) begin
      if (lane == 2'd3 || last) begin
        // Emit and restart from zero so unfilled lanes of the next word read 0.
        dat_q <= merged;
        vld_q <= 1'b1;
        acc_q <= '0;
      end else begin
        acc_q <= merged;
        vld_q <= 1'b0;
      end
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign word_vld = vld_q;
  assign word_dat = dat_q;

endmodule

// File: rtl/ale_chunk_loader.sv
// Host-side writer for the miner chunk memory: trigger, then stream payload bytes as packed words.
// Latency: Start -> Trig +1; byte completing a word -> Wr +1; last Wr -> Done +1.
// Backpressure: ByteRdy_O high only in LOAD; input gaps stall indefinitely, Abort_I drops back to IDLE.
// Ports: Clk/Rst_n; Start_I/Abort_I/ChunkLength_I control; ByteVld_I/ByteData_I/ByteRdy_O byte stream;
//        Trig_O/Wr_O/Data_O miner side; Busy_O/Done_O/Err_O/WordCnt_O status.
module ale_chunk_loader
  import ale_pkg::*;
#(
  parameter int NONCE_BYTE_LEN = DEF_NONCE_BYTE_LEN,
  parameter int MAX_WORDS      = DEF_MAX_WORDS,
  parameter int ADDR_WIDTH     = 7
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start_I,
  input  logic                  Abort_I,
  input  logic [31:0]           ChunkLength_I,
  input  logic                  ByteVld_I,
  input  logic [7:0]            ByteData_I,
  output logic                  ByteRdy_O,
  output logic                  Trig_O,
  output logic                  Wr_O,
  output logic [31:0]           Data_O,
  output logic                  Busy_O,
  output logic                  Done_O,
  output logic                  Err_O,
  output logic [ADDR_WIDTH-1:0] WordCnt_O
);

  // Byte index / payload length width: must hold 4*MAX_WORDS.
  localparam int BW = $clog2(4 * MAX_WORDS + 1);

  ld_state_e             state_q, state_nxt;
  logic                  trig_q, trig_nxt;
  logic                  rdy_q, rdy_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  err_q, err_nxt;

  logic [BW-1:0]         p_len_q;
  logic [31:0]           w_total_q;
  logic [BW-1:0]         byte_idx_q;
  logic [ADDR_WIDTH-1:0] word_cnt_q;

  logic [31:0]           p_calc;
  logic [31:0]           w_calc;
  logic                  legal;
  logic                  start_ok;
  logic                  abort_act;
  logic                  hs;
  logic                  last_byte;
  logic                  word_end;
  logic                  pk_vld;
  logic [31:0]           pk_dat;

  // A ChunkLength below the nonce size wraps to a huge payload, so the upper
  // bound alone also rejects underflow.
  assign p_calc    = ChunkLength_I - 32'(NONCE_BYTE_LEN);
  assign w_calc    = words_from_len(ChunkLength_I, 32'(NONCE_BYTE_LEN));
  assign legal     = (p_calc != 32'd0) && (p_calc <= 32'(4 * MAX_WORDS));
  assign start_ok  = (state_q == ST_IDLE) && Start_I && legal;
  assign abort_act = Abort_I && (state_q != ST_IDLE);

  // Abort wins over a byte presented in the same cycle.
  assign hs        = ByteVld_I && rdy_q && !Abort_I;
  assign last_byte = (byte_idx_q == p_len_q - BW'(1));
  assign word_end  = (byte_idx_q[1:0] == 2'd3) || last_byte;

  always_comb begin
    state_nxt = state_q;
    err_nxt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start_I) begin
          if (legal) state_nxt = ST_TRIG;
          else       err_nxt   = 1'b1;
        end
      end
      ST_TRIG:  state_nxt = ST_LOAD;
      ST_LOAD:  if (hs && last_byte) state_nxt = ST_FLUSH;
      // The final word strobes in the first FLUSH cycle; the counter moves with it.
      ST_FLUSH: if (pk_vld && (32'(word_cnt_q) == w_total_q)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_act) state_nxt = ST_IDLE;

    // Outputs are registered from the next state.
    trig_nxt = (state_nxt == ST_TRIG);
    rdy_nxt  = (state_nxt == ST_LOAD);
    done_nxt = (state_nxt == ST_DONE);
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      trig_q     <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      p_len_q    <= '0;
      w_total_q  <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      trig_q  <= trig_nxt;
      rdy_q   <= rdy_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      if (start_ok) begin
        p_len_q    <= p_calc[BW-1:0];
        w_total_q  <= w_calc;
        byte_idx_q <= '0;
        word_cnt_q <= '0;
      end else if (hs) begin
        byte_idx_q <= byte_idx_q + BW'(1);
        // Count at emission so WordCnt_O steps in the same cycle Wr_O rises.
        if (word_end) word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  byte_packer u_packer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clear    (start_ok || abort_act),
    .push     (hs),
    .last     (last_byte),
    .lane     (byte_idx_q[1:0]),
    .din      (ByteData_I),
    .word_vld (pk_vld),
    .word_dat (pk_dat)
  );

  assign ByteRdy_O = rdy_q;
  assign Trig_O    = trig_q;
  assign Wr_O      = pk_vld;
  assign Data_O    = pk_dat;
  assign Busy_O    = busy_q;
  assign Done_O    = done_q;
  assign Err_O     = err_q;
  assign WordCnt_O = word_cnt_q;

endmodule

// File: tb/tb_ale_chunk_loader.sv
// Bench for ale_chunk_loader: randomized byte streams against a packing/timing model.
// Latency: n/a.
// Backpressure: random ByteVld_I gaps.
module tb_ale_chunk_loader;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start_I = 1'b0;
  logic        Abort_I = 1'b0;
  logic [31:0] ChunkLength_I = '0;
  logic        ByteVld_I = 1'b0;
  logic [7:0]  ByteData_I = '0;
  logic        ByteRdy_O, Trig_O, Wr_O, Busy_O, Done_O, Err_O;
  logic [31:0] Data_O;
  logic [6:0]  WordCnt_O;

  ale_chunk_loader dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start_I(Start_I), .Abort_I(Abort_I),
    .ChunkLength_I(ChunkLength_I), .ByteVld_I(ByteVld_I), .ByteData_I(ByteData_I),
    .ByteRdy_O(ByteRdy_O), .Trig_O(Trig_O), .Wr_O(Wr_O), .Data_O(Data_O),
    .Busy_O(Busy_O), .Done_O(Done_O), .Err_O(Err_O), .WordCnt_O(WordCnt_O)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Cumulative event log; tests take deltas against a snapshot.
  int          trig_cnt = 0, trig_cyc = 0, done_cnt = 0, done_cyc = 0;
  int          err_cnt = 0, err_cyc = 0, rdy_rise_cyc = 0, busy_fall_cyc = 0;
  int          busy_hi_cnt = 0, overlap_cnt = 0;
  logic [31:0] wr_dat[$];
  int          wr_cyc[$];
  logic        prev_rdy = 1'b0, prev_busy = 1'b0;

  always @(negedge Clk) begin
    if (Trig_O) begin trig_cnt <= trig_cnt + 1; trig_cyc <= cyc; end
    if (Done_O) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (Err_O)  begin err_cnt  <= err_cnt + 1;  err_cyc  <= cyc; end
    if (Wr_O) begin wr_dat.push_back(Data_O); wr_cyc.push_back(cyc); end
    if (Trig_O && Wr_O) overlap_cnt <= overlap_cnt + 1;
    if (Busy_O) busy_hi_cnt <= busy_hi_cnt + 1;
    if (ByteRdy_O && !prev_rdy) rdy_rise_cyc <= cyc;
    if (!Busy_O && prev_busy) busy_fall_cyc <= cyc;
    prev_rdy  <= ByteRdy_O;
    prev_busy <= Busy_O;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // One load attempt. base>=0 gives bytes base,base+1,...; otherwise random.
  // abort_after / restart_at / rst_at fire when that many bytes have been accepted (-1 = never).
  task automatic run_load(input string tag, input int len, input int base, input int gap,
                          input int abort_after, input int restart_at, input int rst_at);
    int p, nw, t, sent, budget, tb0, wb0, db0, eb0, bb0, ob0, nwr;
    logic [7:0]  bytes[$];
    logic [31:0] expw[$];
    bit restarted, hs;
    p = len - 24;
    tb0 = trig_cnt; wb0 = wr_dat.size(); db0 = done_cnt; eb0 = err_cnt;
    bb0 = busy_hi_cnt; ob0 = overlap_cnt;

    ChunkLength_I = 32'(len); Start_I = 1'b1; t = cyc;
    step(1);
    Start_I = 1'b0; ChunkLength_I = $urandom;

    if (p < 1 || p > 360) begin
      step(3);
      chk({tag, "/err_cnt"}, 32'(err_cnt - eb0), 1);
      chk({tag, "/err_cyc"}, 32'(err_cyc), 32'(t + 1));
      chk({tag, "/no_trig"}, 32'(trig_cnt - tb0), 0);
      chk({tag, "/no_busy"}, 32'(busy_hi_cnt - bb0), 0);
      return;
    end

    // Reference: little-endian packing, zero-padded final word.
    for (int i = 0; i < p; i++) bytes.push_back(base >= 0 ? 8'(base + i) : 8'($urandom));
    nw = (p + 3) / 4;
    for (int w = 0; w < nw; w++) expw.push_back(32'd0);
    for (int i = 0; i < p; i++) expw[i / 4] = expw[i / 4] | (32'(bytes[i]) << (8 * (i % 4)));

    sent = 0; budget = 0; restarted = 1'b0;
    while (sent < p && budget < 40 * p + 100) begin
      if (sent == abort_after) begin
        ByteVld_I = 1'b1; ByteData_I = bytes[sent]; Abort_I = 1'b1;
        step(1);
        Abort_I = 1'b0; ByteVld_I = 1'b0;
        chk({tag, "/busy_after_abort"}, 32'(Busy_O), 0);
        step(3);
        nwr = wr_dat.size() - wb0;
        chk({tag, "/abort_wr_cnt"}, 32'(nwr), 32'(abort_after / 4));
        for (int i = 0; i < nwr && i < nw; i++) chk({tag, "/abort_word"}, wr_dat[wb0 + i], expw[i]);
        chk({tag, "/abort_no_done"}, 32'(done_cnt - db0), 0);
        chk({tag, "/abort_wordcnt"}, 32'(WordCnt_O), 32'(abort_after / 4));
        return;
      end
      if (sent == rst_at) begin
        ByteVld_I = 1'b0;
        Rst_n = 1'b0;
        #1;
        chk({tag, "/rst_ctl"}, 32'({ByteRdy_O, Trig_O, Wr_O, Done_O, Err_O, Busy_O}), 0);
        chk({tag, "/rst_data"}, Data_O, 0);
        chk({tag, "/rst_cnt"}, 32'(WordCnt_O), 0);
        step(1);
        Rst_n = 1'b1;
        step(1);
        return;
      end
      if (sent == restart_at && !restarted) begin
        Start_I = 1'b1; ChunkLength_I = 32'(len + 40); restarted = 1'b1;
      end
      ByteVld_I  = ($urandom_range(0, 99) >= gap);
      ByteData_I = ByteVld_I ? bytes[sent] : 8'($urandom);
      hs = ByteVld_I && ByteRdy_O;
      step(1);
      Start_I = 1'b0;
      budget++;
      if (hs) begin
        sent++;
        if (sent == p) chk({tag, "/rdy_drop"}, 32'(ByteRdy_O), 0);
      end
    end
    ByteVld_I = 1'b0;
    if (sent < p) begin
      chk({tag, "/stream_timeout"}, 32'(sent), 32'(p));
      return;
    end

    budget = 0;
    while (done_cnt == db0 && budget < 20) begin step(1); budget++; end
    chk({tag, "/done_cnt"}, 32'(done_cnt - db0), 1);
    step(3);

    nwr = wr_dat.size() - wb0;
    chk({tag, "/trig_cnt"}, 32'(trig_cnt - tb0), 1);
    chk({tag, "/trig_cyc"}, 32'(trig_cyc), 32'(t + 1));
    chk({tag, "/rdy_rise"}, 32'(rdy_rise_cyc), 32'(t + 2));
    chk({tag, "/wr_cnt"}, 32'(nwr), 32'(nw));
    for (int i = 0; i < nwr && i < nw; i++) chk({tag, "/word"}, wr_dat[wb0 + i], expw[i]);
    if (nwr > 0) begin
      chk({tag, "/trig_gap"}, 32'(wr_cyc[wb0] >= trig_cyc + 2), 1);
      chk({tag, "/done_cyc"}, 32'(done_cyc), 32'(wr_cyc[wb0 + nwr - 1] + 1));
    end
    chk({tag, "/busy_fall"}, 32'(busy_fall_cyc), 32'(done_cyc + 1));
    chk({tag, "/wordcnt"}, 32'(WordCnt_O), 32'(nw));
    chk({tag, "/overlap"}, 32'(overlap_cnt - ob0), 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    step(3);
    chk("reset_ctl", 32'({ByteRdy_O, Trig_O, Wr_O, Done_O, Err_O, Busy_O}), 0);
    chk("reset_data", Data_O, 0);
    chk("reset_cnt", 32'(WordCnt_O), 0);
    Rst_n = 1'b1;
    step(2);
    chk("idle_ctl", 32'({ByteRdy_O, Trig_O, Wr_O, Done_O, Err_O, Busy_O}), 0);

    run_load("basic",      32,   1,  0, -1, -1, -1);
    run_load("gaps",       29, 'hA1, 50, -1, -1, -1);
    run_load("err24",      24,  -1,  0, -1, -1, -1);
    run_load("err20",      20,  -1,  0, -1, -1, -1);
    run_load("err385",    385,  -1,  0, -1, -1, -1);
    run_load("full",      384,  -1, 15, -1, -1, -1);
    run_load("abort",      36,  -1,  0,  6, -1, -1);
    run_load("post_abort", 28,  -1, 20, -1, -1, -1);
    run_load("restart",    40,  -1, 20, -1,  5, -1);
    run_load("rst",        40,  -1,  0, -1, -1,  3);
    run_load("post_rst",   32,   1,  0, -1, -1, -1);
    for (int k = 0; k < 8; k++)
      run_load("rand", 25 + int'($urandom_range(0, 79)), -1, int'($urandom_range(0, 50)), -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
